// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared definitions for the 8259A interrupt-acknowledge sequencer and the
// priority resolver: level count, spurious level, FSM state encodings and the
// bit/level helper functions used by both sides.
package interrupt_ack_sequencer_pkg;

   localparam int         NUM_LEVELS     = 8;
   localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_ACK1 = 2'd2;
   localparam logic [1:0] ST_ACK2 = 2'd3;

   // result[i] = value[(i + amount) mod 8]
   function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
      logic [7:0] result;
      logic [2:0] src;
      result = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         src       = 3'(i) + amount;
         result[i] = value[src];
      end
      return result;
   endfunction

   // result[i] = value[(i - amount) mod 8]
   function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
      logic [7:0] result;
      logic [2:0] src;
      result = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         src       = 3'(i) - amount;
         result[i] = value[src];
      end
      return result;
   endfunction

   // Lowest set bit wins (bit 0 is highest priority in the unrotated frame).
   function automatic logic [7:0] resolv_priority(input logic [7:0] value);
      return value & (~value + 8'd1);
   endfunction

   function automatic logic [7:0] num2bit(input logic [2:0] level);
      return 8'd1 << level;
   endfunction

   function automatic logic [2:0] bit2num(input logic [7:0] value);
      logic [2:0] level;
      level = 3'd0;
      for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
         if (value[i]) level = 3'(i);
      end
      return level;
   endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_in_service_tracker.sv
// in_service_tracker: holds the in-service register and the priority rotation,
// applies EOI / set-priority commands and computes the highest in-service level.
// Ports:
//   clock, reset                 clock and async active-high reset
//   set_en, set_level            set ISR bit (first INTA of a real request)
//   clear_en, clear_level        clear ISR bit without rotation (auto-EOI)
//   eoi_nonspecific/specific     EOI command pulses, eoi_level selects level
//   rotate_on_eoi, set_priority  rotation controls
//   in_service_register          ISR
//   highest_level_in_service     one-hot highest ISR bit under current rotation
//   priority_rotate              lowest-priority level
module in_service_tracker
   import interrupt_ack_sequencer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       set_en,
   input  logic [2:0] set_level,
   input  logic       clear_en,
   input  logic [2:0] clear_level,
   input  logic       eoi_nonspecific,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   input  logic       rotate_on_eoi,
   input  logic       set_priority,
   output logic [7:0] in_service_register,
   output logic [7:0] highest_level_in_service,
   output logic [2:0] priority_rotate
);

   logic [2:0] top_offset;
   logic [2:0] eoi_target;
   logic       eoi_hit;
   logic [7:0] eoi_mask;
   logic [7:0] auto_mask;
   logic [7:0] set_mask;
   logic [7:0] isr_next;
   logic [2:0] rotate_next;

   // Rotate so the highest-priority level (priority_rotate + 1) sits at bit 0,
   // pick the lowest set bit, then rotate back into level numbering.
   always_comb begin
      top_offset               = priority_rotate + 3'd1;
      highest_level_in_service = rotate_left(resolv_priority(rotate_right(in_service_register, top_offset)),
                                             top_offset);
   end

   always_comb begin
      eoi_target = eoi_level;
      eoi_hit    = 1'b0;
      if (eoi_specific) begin
         eoi_target = eoi_level;
         eoi_hit    = in_service_register[eoi_level];
      end else if (eoi_nonspecific) begin
         eoi_target = bit2num(highest_level_in_service);
         eoi_hit    = |highest_level_in_service;
      end
      eoi_mask  = eoi_hit  ? num2bit(eoi_target)  : 8'd0;
      auto_mask = clear_en ? num2bit(clear_level) : 8'd0;
      set_mask  = set_en   ? num2bit(set_level)   : 8'd0;
      // clears first, then the set, so a same-cycle set on the same bit survives
      isr_next  = (in_service_register & ~eoi_mask & ~auto_mask) | set_mask;

      rotate_next = priority_rotate;
      if (set_priority) begin
         rotate_next = eoi_level;
      end else if (eoi_hit && rotate_on_eoi) begin
         rotate_next = eoi_target;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_service_register <= 8'd0;
         priority_rotate     <= 3'd7;
      end else begin
         in_service_register <= isr_next;
         priority_rotate     <= rotate_next;
      end
   end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: runs the 8086-mode two-pulse INTA handshake around
// the priority resolver, drives INT and the vector, and owns the ISR / rotation
// state through in_service_tracker.
// Build option: define INTACK_AUTO_EOI_EN to clear the acknowledged ISR bit at
// the end of the second INTA (auto-EOI, no rotation).
// Ports:
//   clock, reset                 clock and async active-high reset
//   interrupt[7:0]               one-hot resolver winner, 0 = none
//   ack_edge, ack_end            INTA falling / rising edge pulses
//   eoi_nonspecific, eoi_specific, eoi_level, rotate_on_eoi, set_priority
//                                OCW command pulses
//   vector_base[4:0]             ICW2 T7..T3
//   int_out                      INT to CPU
//   in_service_register, highest_level_in_service, priority_rotate
//                                fed back to the resolver
//   vector_out, vector_valid     vector byte and bus-drive qualifier
//
// state | meaning
// IDLE  | no handshake; waits for a non-zero resolver result
// REQ   | INT asserted, waiting for first INTA
// ACK1  | level latched, waiting for second INTA
// ACK2  | vector on bus until INTA rises
module interrupt_ack_sequencer
   import interrupt_ack_sequencer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] interrupt,
   input  logic       ack_edge,
   input  logic       ack_end,
   input  logic       eoi_nonspecific,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   input  logic       rotate_on_eoi,
   input  logic       set_priority,
   input  logic [4:0] vector_base,
   output logic       int_out,
   output logic [7:0] in_service_register,
   output logic [7:0] highest_level_in_service,
   output logic [2:0] priority_rotate,
   output logic [7:0] vector_out,
   output logic       vector_valid
);

   logic [1:0] state;
   logic [2:0] ack_level;
   logic       isr_set_en;
   logic       auto_clear_en;

   assign isr_set_en = (state == ST_REQ) && ack_edge && (interrupt != 8'd0);

`ifdef INTACK_AUTO_EOI_EN
   // A spurious handshake latched level 7 without setting it; since auto-EOI
   // keeps the ISR empty outside ACK1/ACK2, ISR[7] is already clear then.
   assign auto_clear_en = (state == ST_ACK2) && ack_end;
`else
   assign auto_clear_en = 1'b0;
`endif

   in_service_tracker u_tracker (
      .clock                    (clock),
      .reset                    (reset),
      .set_en                   (isr_set_en),
      .set_level                (bit2num(interrupt)),
      .clear_en                 (auto_clear_en),
      .clear_level              (ack_level),
      .eoi_nonspecific          (eoi_nonspecific),
      .eoi_specific             (eoi_specific),
      .eoi_level                (eoi_level),
      .rotate_on_eoi            (rotate_on_eoi),
      .set_priority             (set_priority),
      .in_service_register      (in_service_register),
      .highest_level_in_service (highest_level_in_service),
      .priority_rotate          (priority_rotate)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         ack_level    <= 3'd0;
         int_out      <= 1'b0;
         vector_out   <= 8'd0;
         vector_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (interrupt != 8'd0) begin
                  state   <= ST_REQ;
                  int_out <= 1'b1;
               end
            end
            ST_REQ: begin
               // a request withdrawn before INTA is answered as spurious
               if (ack_edge) begin
                  ack_level <= (interrupt != 8'd0) ? bit2num(interrupt) : SPURIOUS_LEVEL;
                  int_out   <= 1'b0;
                  state     <= ST_ACK1;
               end
            end
            ST_ACK1: begin
               if (ack_edge) begin
                  vector_out   <= {vector_base, ack_level};
                  vector_valid <= 1'b1;
                  state        <= ST_ACK2;
               end
            end
            ST_ACK2: begin
               if (ack_end) begin
                  vector_valid <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
Sequences the 8259A interrupt-acknowledge cycle around the priority resolver. It consumes the resolver's one-hot interrupt result and owns the in-service register (ISR), the priority rotation state and the INT line. It runs the two-pulse 8086-mode INTA handshake and applies EOI / rotate / set-priority commands decoded by the OCW logic. It feeds in_service_register, highest_level_in_service and priority_rotate back to the resolver.

Parameters:
NUM_LEVELS, 8, number of IR levels; fixed at 8, exposed for package consistency only.
SPURIOUS_LEVEL, 7, level reported when a request is withdrawn before the first INTA.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
interrupt  input  8  one-hot winner from the priority resolver; 0 = none
ack_edge  input  1  one-cycle pulse per INTA falling edge (synchronised upstream)
ack_end  input  1  one-cycle pulse per INTA rising edge
eoi_nonspecific  input  1  pulse: clear the highest in-service bit
eoi_specific  input  1  pulse: clear the ISR bit selected by eoi_level
eoi_level  input  3  level for specific EOI / set-priority
rotate_on_eoi  input  1  qualifies either EOI pulse: rotate priority to the cleared level
set_priority  input  1  pulse: priority_rotate <= eoi_level
vector_base  input  5  ICW2 T7..T3
int_out  output  1  INT to CPU
in_service_register  output  8  ISR
highest_level_in_service  output  8  one-hot highest-priority ISR bit under current rotation; 0 if ISR empty
priority_rotate  output  3  rotation amount; the level equal to priority_rotate is lowest priority
vector_out  output  8  {vector_base, latched level}
vector_valid  output  1  vector_out is to be driven on the data bus

Behaviour:
- Clock and reset: single clock domain. reset is asynchronous and active-high. All state updates on the rising edge of clock.
- Reset values: int_out=0, ISR=0, priority_rotate=7 (IR0 highest), vector_out=0, vector_valid=0, state=IDLE. Reset mid-handshake aborts it; all state returns to these values.
- FSM states: IDLE, REQ, ACK1, ACK2.
- IDLE: interrupt!=0 -> REQ. int_out rises in the cycle after entry (registered, 1-cycle latency from interrupt).
- REQ on ack_edge:
  - Latch level = bit2num(interrupt) and set that ISR bit.
  - If interrupt==0 at that edge: latch SPURIOUS_LEVEL and leave ISR unchanged (spurious).
  - int_out=0 from the next cycle. -> ACK1.
- REQ with interrupt dropping to 0 before any ack_edge: stay in REQ, int_out held. The spurious path covers this case.
- ACK1 on ack_edge: vector_out <= {vector_base, level}, vector_valid=1 next cycle -> ACK2.
- ACK2 on ack_end: vector_valid=0 next cycle -> IDLE. IDLE re-evaluates interrupt on the following cycle.
- ack_end outside ACK2 is ignored. Extra ack_edge in ACK2 is ignored.
- EOI:
  - Non-specific EOI clears the bit in highest_level_in_service.
  - Specific EOI clears ISR[eoi_level].
  - An EOI with an empty target is a no-op.
  - With rotate_on_eoi=1, priority_rotate <= cleared level. For a non-specific EOI with empty ISR, no rotation occurs.
  - Both EOI pulses in the same cycle: specific EOI takes precedence.
- Same-cycle collisions:
  - ISR set (REQ ack_edge) and EOI clear in the same cycle: the clear is applied first, then the set, so the set wins on the same bit.
  - set_priority in the same cycle as a rotating EOI: set_priority wins.
- highest_level_in_service is combinational from ISR and priority_rotate. It is used by the EOI logic in the same cycle.
- priority_rotate and ISR changes are visible to the resolver the cycle after the command.

Optional Feature:
INTACK_AUTO_EOI_EN.
- Defined: the ISR bit set at the first ack_edge is cleared on ack_end in ACK2 (auto-EOI). There is no rotation. A same-cycle eoi_specific is still honoured. The ISR is therefore only non-zero during ACK1/ACK2.
- Undefined: the ISR bit persists until an explicit EOI command.

Decomposition:
- Shared package (common with the resolver):
  - rotate_right, rotate_left, resolv_priority, num2bit, bit2num functions.
  - FSM state localparams.
  - SPURIOUS_LEVEL constant.
- Sub-module: in_service_tracker. It holds the ISR and priority_rotate, applies EOI/set-priority, and computes highest_level_in_service. The FSM stays in the top module.

Test Plan:
- interrupt=0000_0100 in IDLE, vector_base=5'b01000 -> int_out=1 after 1 cycle. First ack_edge: ISR=0000_0100, int_out=0. Second ack_edge: vector_out=8'h42, vector_valid=1. ack_end: vector_valid=0.
- ISR=0000_0110, priority_rotate=7, eoi_nonspecific -> ISR=0000_0100. With rotate_on_eoi=1: priority_rotate=1.
- interrupt drops to 0 in REQ, then two ack_edges -> vector_out low bits=3'd7, ISR unchanged.
- eoi_specific level 2 in the same cycle as a REQ ack_edge with interrupt=0000_0100 -> ISR bit 2 remains set.
- Assert reset in ACK2 -> vector_valid=0, ISR=0, priority_rotate=7 immediately (asynchronous). State=IDLE.
- With INTACK_AUTO_EOI_EN: full handshake on IR5 -> ISR=0010_0000 during ACK1/ACK2, 0000_0000 after ack_end.
